// File: rtl/rr_arb_mux.sv
// rr_arb_mux: merges NCH valid/ready producer channels onto one registered
// valid/ready output channel. Arbitration is round-robin (mode=0) or fixed
// priority with channel 0 highest (mode=1). Sustains one transfer per cycle.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous, active-high reset
//   in_data    - NCH*WIDTH, channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   - NCH, per-channel data valid
//   in_ready   - NCH, per-channel accept (one-hot or zero, combinational)
//   mode       - 0 = round-robin, 1 = fixed priority
//   out_data   - WIDTH, registered selected data
//   out_sel    - SELW, index of channel that supplied out_data
//   out_valid  - out_data/out_sel valid
//   out_ready  - downstream accept
//
// SELW must equal ceil(log2(NCH)).
module rr_arb_mux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Requests padded to a power of two so any SELW-bit index is in range;
  // padded slots are never valid, so indices >= NCH are never granted.
  localparam int NSLOT = 1 << SELW;

  logic [SELW-1:0]  last_r;
  logic [NSLOT-1:0] vld_ext_s;
  logic [SELW-1:0]  rr_idx_s;
  logic [SELW-1:0]  grant_idx_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             any_valid_s;
  logic             slot_free_s;
  logic             grant_ok_s;

  // Zero-extend the request vector to the full index space.
  always_comb begin
    vld_ext_s = '0;
    vld_ext_s[NCH-1:0] = in_valid;
  end

  // Select the winning channel index. Loops run from lowest to highest
  // precedence so the last matching assignment is the winner.
  always_comb begin
    grant_idx_s = '0;
    rr_idx_s    = '0;
    if (mode) begin
      // Fixed priority: lowest valid index wins.
      for (int i = NCH - 1; i >= 0; i--) begin
        grant_idx_s = vld_ext_s[SELW'(i)] ? SELW'(i) : grant_idx_s;
      end
    end else begin
      // Round-robin: first valid channel after last, wrapping modulo NCH.
      for (int k = NCH; k >= 1; k--) begin
        rr_idx_s    = SELW'((int'(last_r) + k) % NCH);
        grant_idx_s = vld_ext_s[rr_idx_s] ? rr_idx_s : grant_idx_s;
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      grant_data_s = (grant_idx_s == SELW'(i)) ? in_data[i*WIDTH +: WIDTH] : grant_data_s;
    end
  end

  // Handshake: grant only when the output slot can take a word; held low
  // during reset even though out_valid is already cleared then.
  always_comb begin
    any_valid_s = |in_valid;
    slot_free_s = !out_valid || out_ready;
    grant_ok_s  = slot_free_s && any_valid_s && !rst;
    if (grant_ok_s) begin
      in_ready = {{(NCH-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      in_ready = '0;
    end
  end

  // Output register and round-robin pointer. The pointer follows every grant
  // in both modes so a mode switch resumes fairly from the latest winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last_r    <= SELW'(NCH - 1);
    end else if (grant_ok_s) begin
      out_valid <= 1'b1;
      out_data  <= grant_data_s;
      out_sel   <= grant_idx_s;
      last_r    <= grant_idx_s;
    end else if (out_ready) begin
      // Drain with no replacement word; data/sel keep their last value.
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed testbench for rr_arb_mux (WIDTH=8, NCH=4, SELW=2).
module tb_rr_arb_mux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  int errors;
  int checks;

  rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [SELW-1:0] s,
                         input logic [WIDTH-1:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    chk({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) set_ch(i, 8'(8'h10 + i));
    tick();
    tick();
    chk_out("reset", 1'b0, 2'd0, 8'h00);
    in_valid = 4'b1111;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'h0);

    // Release; channel 0 must win first.
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rr.first_ready", 32'(in_ready), 32'b0001);
    tick(); chk_out("rr0", 1'b1, 2'd0, 8'h10); chk("rr0.ready", 32'(in_ready), 32'b0010);
    tick(); chk_out("rr1", 1'b1, 2'd1, 8'h11); chk("rr1.ready", 32'(in_ready), 32'b0100);
    tick(); chk_out("rr2", 1'b1, 2'd2, 8'h12); chk("rr2.ready", 32'(in_ready), 32'b1000);
    tick(); chk_out("rr3", 1'b1, 2'd3, 8'h13);
    tick(); chk_out("rr4", 1'b1, 2'd0, 8'h10);
    tick(); chk_out("rr5", 1'b1, 2'd1, 8'h11);   // last=1

    // Wrap/skip: move pointer to 2, then only ch1 requests (wraps 3,0,1).
    in_valid = 4'b0100;
    #1; chk("wrap.pre_ready", 32'(in_ready), 32'b0100);
    tick(); chk_out("wrap.pre", 1'b1, 2'd2, 8'h12);   // last=2
    in_valid = 4'b0010;
    #1; chk("wrap.ready", 32'(in_ready), 32'b0010);
    tick(); chk_out("wrap.ch1", 1'b1, 2'd1, 8'h11);   // last=1
    in_valid = 4'b1001;
    #1; chk("skip.ready3", 32'(in_ready), 32'b1000);
    tick(); chk_out("skip.ch3", 1'b1, 2'd3, 8'h13);
    #1; chk("skip.ready0", 32'(in_ready), 32'b0001);
    tick(); chk_out("skip.ch0", 1'b1, 2'd0, 8'h10);   // last=0

    // Fixed priority: ch1 wins every cycle.
    mode     = 1'b1;
    in_valid = 4'b1110;
    for (int n = 0; n < 3; n++) begin
      #1; chk("fp.ready", 32'(in_ready), 32'b0010);
      tick(); chk_out("fp", 1'b1, 2'd1, 8'h11);
    end
    // Back to round-robin from last=1: ch2 next, carrying 0x42.
    set_ch(2, 8'h42);
    mode     = 1'b0;
    #1; chk("mode_sw.ready", 32'(in_ready), 32'b0100);
    chk_out("mode_sw.held", 1'b1, 2'd1, 8'h11);
    tick(); chk_out("mode_sw.ch2", 1'b1, 2'd2, 8'h42);   // last=2

    // Backpressure for 5 cycles with everything requesting.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1; chk("bp.ready", 32'(in_ready), 32'h0);
      tick(); chk_out("bp.hold", 1'b1, 2'd2, 8'h42);
    end
    out_ready = 1'b1;
    #1; chk("bp.release_ready", 32'(in_ready), 32'b1000);
    tick(); chk_out("bp.ch3", 1'b1, 2'd3, 8'h13);

    // Idle drain: single 0x7E on ch0.
    set_ch(0, 8'h7E);
    in_valid = 4'b0001;
    #1; chk("drain.ready", 32'(in_ready), 32'b0001);
    tick(); chk_out("drain.word", 1'b1, 2'd0, 8'h7E);
    in_valid = 4'b0000;
    #1; chk("drain.idle_ready", 32'(in_ready), 32'h0);
    tick(); chk_out("drain.empty1", 1'b0, 2'd0, 8'h7E);
    tick(); chk_out("drain.empty2", 1'b0, 2'd0, 8'h7E);

    // Reset mid-stream with 0xA5 held under backpressure.
    set_ch(1, 8'hA5);
    in_valid = 4'b0010;
    tick(); chk_out("rst_mid.load", 1'b1, 2'd1, 8'hA5);   // last=1
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    tick(); chk_out("rst_mid.held", 1'b1, 2'd1, 8'hA5);
    rst = 1'b1;
    #1;
    chk_out("rst_mid.async", 1'b0, 2'd0, 8'h00);
    out_ready = 1'b1;
    #1; chk("rst_mid.ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1; chk("rst_mid.first_ready", 32'(in_ready), 32'b0001);
    tick(); chk_out("rst_mid.ch0", 1'b1, 2'd0, 8'h7E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
